// File: rtl/ocx_tlx_cmd_sched_pkg.sv
// ocx_tlx_cmd_sched_pkg
// Shared definitions for the TLX VC1 command-read scheduler:
//   - scheduler state encoding
//   - config-space opcode constants
//   - opcode class decode helper
package ocx_tlx_cmd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_t;

  localparam logic [7:0] OP_CFG_RD = 8'hE0;
  localparam logic [7:0] OP_CFG_WR = 8'hE1;

  // 1 = config class (uses CFG credits), 0 = AFU class.
  function automatic logic is_cfg_op(input logic [7:0] opcode);
    return (opcode == OP_CFG_RD) || (opcode == OP_CFG_WR);
  endfunction

endpackage

// File: rtl/ocx_tlx_cmd_sched_if.sv
// ocx_tlx_cmd_sched_if
// Bundles the scheduler's credit, FIFO-head, flush and output signals.
//   slave  : scheduler side (consumes credits/head info, drives pops/credits)
//   master : environment side (FIFO, AFU, CFG, CRC logic)
interface ocx_tlx_cmd_sched_if #(
  parameter int AFU_CRD_WIDTH = 7,
  parameter int CFG_CRD_WIDTH = 4
);
  logic                     cmd_credit_enable;
  logic [AFU_CRD_WIDTH-1:0] afu_tlx_cmd_initial_credit;
  logic [CFG_CRD_WIDTH-1:0] cfg_tlx_initial_credit;
  logic                     afu_tlx_cmd_credit;
  logic                     cfg_tlx_credit_return;
  logic                     cmd_head_valid;
  logic [7:0]               cmd_head_opcode;
  logic                     crc_flush_inprog;
  logic                     crc_flush_done;
  logic                     data_hold_vc1;
  logic                     cmd_rd_ena;
  logic                     rcv_xmt_credit_v;
  logic [AFU_CRD_WIDTH-1:0] afu_credit_cnt;
  logic [CFG_CRD_WIDTH-1:0] cfg_credit_cnt;
  logic                     credit_overflow_err;

  modport slave (
    input  cmd_credit_enable, afu_tlx_cmd_initial_credit, cfg_tlx_initial_credit,
           afu_tlx_cmd_credit, cfg_tlx_credit_return, cmd_head_valid,
           cmd_head_opcode, crc_flush_inprog, crc_flush_done, data_hold_vc1,
    output cmd_rd_ena, rcv_xmt_credit_v, afu_credit_cnt, cfg_credit_cnt,
           credit_overflow_err
  );

  modport master (
    output cmd_credit_enable, afu_tlx_cmd_initial_credit, cfg_tlx_initial_credit,
           afu_tlx_cmd_credit, cfg_tlx_credit_return, cmd_head_valid,
           cmd_head_opcode, crc_flush_inprog, crc_flush_done, data_hold_vc1,
    input  cmd_rd_ena, rcv_xmt_credit_v, afu_credit_cnt, cfg_credit_cnt,
           credit_overflow_err
  );
endinterface

// File: rtl/ocx_tlx_credit_ctr.sv
// ocx_tlx_credit_ctr
// Credit counter with a grant cap captured at load time.
//   clk, reset_n : clock, synchronous active-low reset
//   load/init_val: capture count and cap from the initial grant
//   dec          : one credit consumed this cycle
//   inc          : one credit returned this cycle
//   count        : current credit count
//   ovf          : combinational pulse, a return arrived while count == cap
module ocx_tlx_credit_ctr #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] init_val,
  input  logic             dec,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cap_q, cap_d;

  always_comb begin
    count_d = count_q;
    cap_d   = cap_q;
    ovf     = 1'b0;
    if (load) begin
      count_d = init_val;
      cap_d   = init_val;
    end else begin
      case ({dec, inc})
        2'b10: count_d = count_q - 1'b1;   // issue guarantees count_q != 0
        2'b01: begin
          if (count_q == cap_q) ovf = 1'b1; // saturate at the grant
          else                  count_d = count_q + 1'b1;
        end
        default: count_d = count_q;        // idle, or consume+return nets out
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      cap_q   <= '0;
    end else begin
      count_q <= count_d;
      cap_q   <= cap_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/ocx_tlx_cmd_sched.sv
// ocx_tlx_cmd_sched
// VC1 command-FIFO read scheduler. Pops the FIFO head when its opcode class
// holds credits, sequences the initial host credit grant, and pauses issue
// during CRC flush.
//   tlx_clk : sole clock
//   reset_n : synchronous active-low reset
//   bus     : scheduler side of ocx_tlx_cmd_sched_if (credits, head, flush,
//             cmd_rd_ena / rcv_xmt_credit_v / counts / overflow error)
module ocx_tlx_cmd_sched
  import ocx_tlx_cmd_sched_pkg::*;
#(
  parameter int CMD_ADDR_WIDTH = 6,
  parameter int AFU_CRD_WIDTH  = 7,
  parameter int CFG_CRD_WIDTH  = 4
) (
  input logic                  tlx_clk,
  input logic                  reset_n,
  ocx_tlx_cmd_sched_if.slave   bus
);
  localparam logic [CMD_ADDR_WIDTH:0] INIT_CNT_RST = {1'b1, {CMD_ADDR_WIDTH{1'b0}}};

  sched_state_t              state_q, state_d;
  logic [CMD_ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
  logic                      rd_ena_q, rd_ena_d;
  logic                      xmt_v_q, xmt_v_d;
  logic                      err_q, err_d;

  logic [AFU_CRD_WIDTH-1:0]  afu_cnt;
  logic [CFG_CRD_WIDTH-1:0]  cfg_cnt;
  logic                      afu_ovf, cfg_ovf;
  logic                      head_is_cfg, cls_has_crd, issue;
  logic                      crd_load, crd_accept;

  assign head_is_cfg = is_cfg_op(bus.cmd_head_opcode);
  assign cls_has_crd = head_is_cfg ? (cfg_cnt != '0) : (afu_cnt != '0);
  // rd_ena_q in the term gives the one-cycle gap the FIFO needs to advance.
  assign issue = (state_q == ST_RUN) && bus.cmd_head_valid && !bus.data_hold_vc1 &&
                 !bus.crc_flush_inprog && !rd_ena_q && cls_has_crd;
  assign crd_load   = (state_q == ST_INIT) && bus.cmd_credit_enable;
  // Returns before the grant is loaded would corrupt the cap check.
  assign crd_accept = (state_q == ST_RUN) || (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_INIT;
      ST_INIT:  if (bus.cmd_credit_enable) state_d = ST_RUN;
      ST_RUN:   if (bus.crc_flush_inprog)  state_d = ST_FLUSH;
      ST_FLUSH: if (bus.crc_flush_done)    state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    init_cnt_d = init_cnt_q;
    rd_ena_d   = issue;
    // During the host grant window every cycle returns a credit anyway, so
    // pops there are already covered and add no pulse.
    if (init_cnt_q != '0) begin
      init_cnt_d = init_cnt_q - 1'b1;
      xmt_v_d    = 1'b1;
    end else begin
      xmt_v_d    = issue;
    end
    err_d = err_q | afu_ovf | cfg_ovf;
  end

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      init_cnt_q <= INIT_CNT_RST;
      rd_ena_q   <= 1'b0;
      xmt_v_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_ena_q   <= rd_ena_d;
      xmt_v_q    <= xmt_v_d;
      err_q      <= err_d;
    end
  end

  ocx_tlx_credit_ctr #(.WIDTH(AFU_CRD_WIDTH)) u_afu_ctr (
    .clk      (tlx_clk),
    .reset_n  (reset_n),
    .load     (crd_load),
    .init_val (bus.afu_tlx_cmd_initial_credit),
    .dec      (issue && !head_is_cfg),
    .inc      (crd_accept && bus.afu_tlx_cmd_credit),
    .count    (afu_cnt),
    .ovf      (afu_ovf)
  );

  ocx_tlx_credit_ctr #(.WIDTH(CFG_CRD_WIDTH)) u_cfg_ctr (
    .clk      (tlx_clk),
    .reset_n  (reset_n),
    .load     (crd_load),
    .init_val (bus.cfg_tlx_initial_credit),
    .dec      (issue && head_is_cfg),
    .inc      (crd_accept && bus.cfg_tlx_credit_return),
    .count    (cfg_cnt),
    .ovf      (cfg_ovf)
  );

  assign bus.cmd_rd_ena          = rd_ena_q;
  assign bus.rcv_xmt_credit_v    = xmt_v_q;
  assign bus.afu_credit_cnt      = afu_cnt;
  assign bus.cfg_credit_cnt      = cfg_cnt;
  assign bus.credit_overflow_err = err_q;
endmodule

// File: tb/tb_ocx_tlx_cmd_sched.sv
// tb_ocx_tlx_cmd_sched
// Directed bench for ocx_tlx_cmd_sched: host grant window, class credit
// issue/blocking, config heads, CRC flush, cap saturation and mid-stream reset.
module tb_ocx_tlx_cmd_sched;
  logic tlx_clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  ocx_tlx_cmd_sched_if #(.AFU_CRD_WIDTH(7), .CFG_CRD_WIDTH(4)) bus ();

  ocx_tlx_cmd_sched #(.CMD_ADDR_WIDTH(6), .AFU_CRD_WIDTH(7), .CFG_CRD_WIDTH(4)) dut (
    .tlx_clk (tlx_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial tlx_clk = 1'b0;
  always #5 tlx_clk = ~tlx_clk;

  task automatic tick();
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},  {31'b0, bus.cmd_rd_ena}, 32'd0);
    check({tag, "_xmt"}, {31'b0, bus.rcv_xmt_credit_v}, 32'd0);
    check({tag, "_afu"}, {25'b0, bus.afu_credit_cnt}, 32'd0);
    check({tag, "_cfg"}, {28'b0, bus.cfg_credit_cnt}, 32'd0);
    check({tag, "_err"}, {31'b0, bus.credit_overflow_err}, 32'd0);
  endtask

  // Called right after reset_n is released. Measures the host grant window
  // and injects an AFU return while in INIT, which must be ignored.
  task automatic grant_window(input string tag);
    int highs = 0;
    int pops = 0;
    int first_low = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.rcv_xmt_credit_v) highs++;
      else if (first_low < 0) first_low = i;
      if (bus.cmd_rd_ena) pops++;
      bus.afu_tlx_cmd_credit = (i == 0);
    end
    bus.afu_tlx_cmd_credit = 1'b0;
    check({tag, "_highs"},     highs, 32'd64);
    check({tag, "_first_low"}, first_low, 32'd64);
    check({tag, "_pops"},      pops, 32'd0);
    check({tag, "_init_ret_ignored"}, {25'b0, bus.afu_credit_cnt}, 32'd0);
    check({tag, "_init_ret_no_err"},  {31'b0, bus.credit_overflow_err}, 32'd0);
  endtask

  task automatic load_credits(input logic [6:0] afu, input logic [3:0] cfg);
    bus.afu_tlx_cmd_initial_credit = afu;
    bus.cfg_tlx_initial_credit     = cfg;
    bus.cmd_credit_enable          = 1'b1;
    tick();
    bus.cmd_credit_enable          = 1'b0;
  endtask

  initial begin
    int pops;
    int p_first;
    int p_second;

    reset_n = 1'b0;
    bus.cmd_credit_enable = 1'b0;
    bus.afu_tlx_cmd_initial_credit = '0;
    bus.cfg_tlx_initial_credit = '0;
    bus.afu_tlx_cmd_credit = 1'b0;
    bus.cfg_tlx_credit_return = 1'b0;
    bus.cmd_head_valid = 1'b0;
    bus.cmd_head_opcode = 8'h00;
    bus.crc_flush_inprog = 1'b0;
    bus.crc_flush_done = 1'b0;
    bus.data_hold_vc1 = 1'b0;

    // Reset state and host grant window
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    grant_window("grant1");

    // AFU=2, CFG=1; back-to-back AFU heads
    load_credits(7'd2, 4'd1);
    check("init_afu", {25'b0, bus.afu_credit_cnt}, 32'd2);
    check("init_cfg", {28'b0, bus.cfg_credit_cnt}, 32'd1);
    bus.cmd_head_opcode = 8'h10;
    bus.cmd_head_valid  = 1'b1;
    pops = 0; p_first = -1; p_second = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("xmt_follows_pop", {31'b0, bus.rcv_xmt_credit_v}, {31'b0, bus.cmd_rd_ena});
      if (bus.cmd_rd_ena) begin
        if (pops == 0) p_first = i;
        else if (pops == 1) p_second = i;
        pops++;
      end
    end
    check("afu_pops", pops, 32'd2);
    check("afu_first_pop_latency", p_first, 32'd0);
    check("afu_pop_spacing", p_second - p_first, 32'd2);
    check("afu_drained", {25'b0, bus.afu_credit_cnt}, 32'd0);

    // One AFU return unblocks the third head
    bus.afu_tlx_cmd_credit = 1'b1;
    tick();
    bus.afu_tlx_cmd_credit = 1'b0;
    check("afu_ret_cnt", {25'b0, bus.afu_credit_cnt}, 32'd1);
    check("afu_ret_no_pop_yet", {31'b0, bus.cmd_rd_ena}, 32'd0);
    tick();
    check("afu_third_pop", {31'b0, bus.cmd_rd_ena}, 32'd1);
    check("afu_third_cnt", {25'b0, bus.afu_credit_cnt}, 32'd0);
    bus.cmd_head_valid = 1'b0;
    tick();

    // Config class: consume the CFG credit, then block on 0xE1
    bus.afu_tlx_cmd_credit = 1'b1;
    tick();
    bus.afu_tlx_cmd_credit = 1'b0;
    check("afu_avail", {25'b0, bus.afu_credit_cnt}, 32'd1);
    bus.cmd_head_opcode = 8'hE0;
    bus.cmd_head_valid  = 1'b1;
    tick();
    check("cfg_rd_pop", {31'b0, bus.cmd_rd_ena}, 32'd1);
    check("cfg_rd_cnt", {28'b0, bus.cfg_credit_cnt}, 32'd0);
    bus.cmd_head_opcode = 8'hE1;
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cmd_rd_ena) pops++;
    end
    check("cfg_blocked_pops", pops, 32'd0);
    check("cfg_blocked_afu_kept", {25'b0, bus.afu_credit_cnt}, 32'd1);
    bus.cfg_tlx_credit_return = 1'b1;
    tick();
    bus.cfg_tlx_credit_return = 1'b0;
    check("cfg_ret_cnt", {28'b0, bus.cfg_credit_cnt}, 32'd1);
    check("cfg_ret_no_pop_yet", {31'b0, bus.cmd_rd_ena}, 32'd0);
    tick();
    check("cfg_wr_pop", {31'b0, bus.cmd_rd_ena}, 32'd1);
    check("cfg_wr_cnt", {28'b0, bus.cfg_credit_cnt}, 32'd0);
    bus.cmd_head_valid = 1'b0;
    tick();

    // CRC flush rising together with a valid issue condition
    bus.cmd_head_opcode  = 8'h20;
    bus.cmd_head_valid   = 1'b1;
    bus.crc_flush_inprog = 1'b1;
    tick();
    check("flush_edge_no_pop", {31'b0, bus.cmd_rd_ena}, 32'd0);
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cmd_rd_ena) pops++;
    end
    check("flush_pops", pops, 32'd0);
    check("flush_afu_kept", {25'b0, bus.afu_credit_cnt}, 32'd1);
    bus.crc_flush_inprog = 1'b0;
    bus.crc_flush_done   = 1'b1;
    tick();
    bus.crc_flush_done   = 1'b0;
    check("flush_done_no_pop", {31'b0, bus.cmd_rd_ena}, 32'd0);
    tick();
    check("flush_resume_pop", {31'b0, bus.cmd_rd_ena}, 32'd1);
    check("flush_resume_cnt", {25'b0, bus.afu_credit_cnt}, 32'd0);
    bus.cmd_head_valid = 1'b0;
    tick();

    // Mid-stream reset with nonzero counts
    bus.afu_tlx_cmd_credit    = 1'b1;
    bus.cfg_tlx_credit_return = 1'b1;
    tick();
    bus.afu_tlx_cmd_credit    = 1'b0;
    bus.cfg_tlx_credit_return = 1'b0;
    check("pre_rst_afu", {25'b0, bus.afu_credit_cnt}, 32'd1);
    check("pre_rst_cfg", {28'b0, bus.cfg_credit_cnt}, 32'd1);
    bus.cmd_head_valid = 1'b1;
    tick();
    check("pre_rst_pop", {31'b0, bus.cmd_rd_ena}, 32'd1);
    reset_n = 1'b0;
    bus.cmd_head_valid = 1'b0;
    tick();
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    grant_window("grant2");

    // AFU grant 3: return coinciding with issue nets out, no error
    load_credits(7'd3, 4'd0);
    check("cap_init_afu", {25'b0, bus.afu_credit_cnt}, 32'd3);
    check("cap_init_cfg", {28'b0, bus.cfg_credit_cnt}, 32'd0);
    bus.cmd_head_opcode    = 8'h30;
    bus.cmd_head_valid     = 1'b1;
    bus.afu_tlx_cmd_credit = 1'b1;
    tick();
    bus.afu_tlx_cmd_credit = 1'b0;
    bus.cmd_head_valid     = 1'b0;
    check("coinc_pop", {31'b0, bus.cmd_rd_ena}, 32'd1);
    check("coinc_cnt", {25'b0, bus.afu_credit_cnt}, 32'd3);
    tick();
    check("coinc_no_err", {31'b0, bus.credit_overflow_err}, 32'd0);

    // Return at cap saturates and sets sticky error
    bus.afu_tlx_cmd_credit = 1'b1;
    tick();
    bus.afu_tlx_cmd_credit = 1'b0;
    check("ovf_cnt", {25'b0, bus.afu_credit_cnt}, 32'd3);
    check("ovf_err", {31'b0, bus.credit_overflow_err}, 32'd1);
    tick(); tick(); tick();
    check("ovf_err_sticky", {31'b0, bus.credit_overflow_err}, 32'd1);

    // Zero CFG grant: any return overflows
    reset_n = 1'b0;
    tick();
    check("rst_clears_err", {31'b0, bus.credit_overflow_err}, 32'd0);
    reset_n = 1'b1;
    tick();
    load_credits(7'd3, 4'd0);
    bus.cfg_tlx_credit_return = 1'b1;
    tick();
    bus.cfg_tlx_credit_return = 1'b0;
    check("zero_grant_cnt", {28'b0, bus.cfg_credit_cnt}, 32'd0);
    check("zero_grant_err", {31'b0, bus.credit_overflow_err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ocx_tlx_cmd_sched.md
# ocx_tlx_cmd_sched

Command-read scheduler for the TLX receive command FIFO (VC1). Decides each cycle whether to pop the FIFO head, based on the opcode class and the credits held for that class. AFU commands use AFU command credits. Config commands (opcodes 0xE0/0xE1) use CFG credits. The block also sequences the initial-credit grant to the host transmit side and holds off reads during CRC flush.

## Interface
- CMD_ADDR_WIDTH, 6: FIFO address width; FIFO depth and initial host credit count are 2**CMD_ADDR_WIDTH.
- AFU_CRD_WIDTH, 7: AFU credit counter width.
- CFG_CRD_WIDTH, 4: CFG credit counter width.

- tlx_clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_credit_enable  in  1  initial credits are valid; sampled in INIT.
- afu_tlx_cmd_initial_credit  in  AFU_CRD_WIDTH  AFU credit grant.
- cfg_tlx_initial_credit  in  CFG_CRD_WIDTH  CFG credit grant.
- afu_tlx_cmd_credit  in  1  one AFU credit returned (pulse).
- cfg_tlx_credit_return  in  1  one CFG credit returned (pulse).
- cmd_head_valid  in  1  FIFO non-empty and the head opcode is stable.
- cmd_head_opcode  in  8  opcode of the FIFO head entry.
- crc_flush_inprog  in  1  CRC flush active.
- crc_flush_done  in  1  CRC flush complete (pulse).
- data_hold_vc1  in  1  stall; no new reads issued while high.
- cmd_rd_ena  out  1  pop FIFO head (registered).
- rcv_xmt_credit_v  out  1  one VC1 credit to the host per cycle high (registered).
- afu_credit_cnt  out  AFU_CRD_WIDTH  current AFU credits.
- cfg_credit_cnt  out  CFG_CRD_WIDTH  current CFG credits.
- credit_overflow_err  out  1  sticky: a credit was returned beyond its grant.

## Operation
- States: IDLE → INIT → RUN ↔ FLUSH. Reset forces IDLE from any state, mid-operation included.
- IDLE: lasts one cycle after reset deasserts, then moves to INIT.
- INIT: when cmd_credit_enable=1, load both counters and the grant caps from the initial-credit inputs, then go to RUN. Credit returns seen in IDLE or INIT are ignored.
- Host credit init: an init counter of width CMD_ADDR_WIDTH+1 resets to 2**CMD_ADDR_WIDTH.
  - While the counter is nonzero, rcv_xmt_credit_v=1 and the counter decrements every cycle, independent of state.
  - After the counter reaches zero, rcv_xmt_credit_v is the registered copy of the pop decision, asserted in the same cycle as cmd_rd_ena.
- Class: CFG if cmd_head_opcode is 0xE0 or 0xE1; otherwise AFU.
- Issue condition, evaluated in cycle N; all terms must hold:
  - state is RUN;
  - cmd_head_valid=1;
  - data_hold_vc1=0;
  - crc_flush_inprog=0;
  - cmd_rd_ena=0 in cycle N;
  - the head's class counter is nonzero.
  When the condition holds, cmd_rd_ena=1 in cycle N+1 and the class counter decrements at that same edge.
- Class blocking: a head whose class has zero credits blocks the FIFO; commands are never reordered.
- Counter update per cycle (net):
  - decrement and return together → unchanged;
  - return only → +1, unless the count equals its cap. At the cap the count holds and credit_overflow_err is set (cleared only by reset).
  - The decrement never underflows, because issue requires a nonzero count.
- A zero initial grant leaves that class permanently blocked until credits are returned. Those returns count toward an overflow, because the cap is 0.
- FLUSH: entered from RUN when crc_flush_inprog=1. An already-registered cmd_rd_ena still completes. No new issue. Credit returns are still accepted. Return to RUN on crc_flush_done.

## Timing
- Reset values: cmd_rd_ena=0, afu_credit_cnt=0, cfg_credit_cnt=0, credit_overflow_err=0, state=IDLE. rcv_xmt_credit_v=0 while reset_n=0 and 1 from the first cycle after reset deasserts.
- Decision-to-pop latency is 1 cycle.
- Peak throughput is one pop per 2 cycles. The gap cycle lets the FIFO present the next head.
- Host credit grant: exactly 2**CMD_ADDR_WIDTH consecutive cycles of rcv_xmt_credit_v. Pops during this window add no extra pulse, since the output is already high; each such pop's credit is covered by the init count.
- credit_overflow_err rises one cycle after the offending return.

## Structure
- Package ocx_tlx_cmd_sched_pkg holds:
  - state encoding (IDLE, INIT, RUN, FLUSH);
  - opcode constants OP_CFG_RD=8'hE0 and OP_CFG_WR=8'hE1;
  - a class-decode function.
- Sub-module ocx_tlx_credit_ctr, parameterised by width, instantiated twice (AFU, CFG). Ports: load, init value, dec, inc, count, overflow pulse. Cap register and saturation logic live inside it.
- The top level holds the FSM, the init counter, the issue logic and the sticky error.

## Test plan
- Reset then idle, with CMD_ADDR_WIDTH=6 → rcv_xmt_credit_v high for exactly 64 cycles, then low; cmd_rd_ena stays 0.
- Initial credits AFU=2, CFG=1; four AFU heads back-to-back → exactly 2 pops, spaced 2 cycles apart; afu_credit_cnt=0; the third head stalls. One afu_tlx_cmd_credit pulse → third pop one cycle after the counter becomes 1.
- Head 0xE1 with cfg_credit_cnt=0 and AFU credits available → no pop; one cfg_tlx_credit_return → pop, then cfg_credit_cnt=0.
- crc_flush_inprog rises in the same cycle as a valid issue condition → no pop. While flushing, with heads present, no pop; crc_flush_done → pops resume 1 cycle after the return to RUN.
- AFU grant 3 at count 3, afu_tlx_cmd_credit pulse → count stays 3 and credit_overflow_err=1 until reset. The same return coinciding with an issue → count stays 3 and no error.
- reset_n low for 1 cycle mid-stream with counts nonzero → all outputs return to their reset values, and the 64-cycle host grant restarts.
